// File: rtl/datamemory_param.sv
// Parametrised data memory: DEPTH words of DATA_W bits, a bulk loader fed by a
// valid/ready stream, a random-access read/write bus port and a registered
// window of WIN words exposed as one flat vector.
module datamemory_param #(
  parameter int DATA_W    = 12,
  parameter int IN_W      = 17,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 64,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 16,
  parameter int WIN_BASE  = 0,
  parameter int WIN       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_writing,
  input  logic                  ld_valid,
  input  logic [IN_W-1:0]       ld_data,
  output logic                  ld_ready,
  output logic                  load_busy,
  output logic                  load_done,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [IN_W-1:0]       datain,
  output logic [DATA_W-1:0]     dataout,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic [WIN*DATA_W-1:0] win_data
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = $clog2(LOAD_LEN + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next;
  logic              start_q;
  logic              start_edge;
  logic              beat;
  logic              last_beat;
  logic              addr_ok;
  logic              bus_wr;
  logic [MEM_AW-1:0] bus_idx;
  logic [MEM_AW-1:0] load_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] win_q [WIN];
  logic              unused_hi;

  assign start_edge = start_writing & ~start_q;
  assign ld_ready   = (state == LOAD);
  assign load_busy  = (state == LOAD);
  assign load_done  = (state == DONE);
  assign beat       = ld_valid & ld_ready;
  assign last_beat  = beat && (ptr == PTR_W'(LOAD_LEN - 1));
  assign addr_ok    = ({1'b0, addr} < DEPTH_L);
  assign bus_idx    = addr[MEM_AW-1:0];
  assign load_idx   = MEM_AW'(LOAD_BASE) + MEM_AW'(ptr);
  assign bus_wr     = write_en && (state != LOAD) && addr_ok;

  // Bus bits above the stored width are intentionally discarded.
  assign unused_hi  = ^{ld_data[IN_W-1:DATA_W], datain[IN_W-1:DATA_W]};

  // Loader state, beat pointer and the delayed start used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      start_q <= start_writing;
    end
  end

  // Next-state logic: a fresh start edge restarts from ptr 0 unless a load is running.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          ptr_next = ptr + 1'b1;
        end
        if (last_beat) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    // One storage word; loader and bus writes never coincide since the bus is blocked during LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[k] <= '0;
      end else if (beat && (load_idx == MEM_AW'(k))) begin
        mem[k] <= ld_data[DATA_W-1:0];
      end else if (bus_wr && (bus_idx == MEM_AW'(k))) begin
        mem[k] <= datain[DATA_W-1:0];
      end
    end
  end

  // Registered read port (read-first) and rejection flag; dataout holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= read_en;
      addr_err <= (write_en && ((state == LOAD) || !addr_ok)) || (read_en && !addr_ok);
      if (read_en) begin
        dataout <= addr_ok ? mem[bus_idx] : '0;
      end
    end
  end

  for (genvar k = 0; k < WIN; k++) begin : g_win
    // Window copy trails the memory by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        win_q[k] <= '0;
      end else begin
        win_q[k] <= mem[WIN_BASE + k];
      end
    end
    assign win_data[k*DATA_W +: DATA_W] = win_q[k];
  end

endmodule

// File: tb/tb_datamemory_param.sv
// Self-checking bench for datamemory_param: directed scenarios plus random
// traffic, compared every cycle against a flag/counter reference model.
module tb_datamemory_param;

  logic         clk;
  logic         rst_n;
  logic         start_writing;
  logic         ld_valid;
  logic [16:0]  ld_data;
  logic         ld_ready;
  logic         load_busy;
  logic         load_done;
  logic         write_en;
  logic         read_en;
  logic [11:0]  addr;
  logic [16:0]  datain;
  logic [11:0]  dataout;
  logic         rd_valid;
  logic         addr_err;
  logic [191:0] win_data;

  int errors;
  int checks;

  logic [11:0]  m_mem [64];
  bit           m_loading;
  bit           m_done;
  bit           m_start_prev;
  int           m_count;
  logic [11:0]  e_dout;
  bit           e_rdv;
  bit           e_err;
  logic [191:0] e_win;

  datamemory_param dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_writing (start_writing),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .write_en      (write_en),
    .read_en       (read_en),
    .addr          (addr),
    .datain        (datain),
    .dataout       (dataout),
    .rd_valid      (rd_valid),
    .addr_err      (addr_err),
    .win_data      (win_data)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("ld_ready",  192'(ld_ready),  192'(m_loading));
    checkOutput("load_busy", 192'(load_busy), 192'(m_loading));
    checkOutput("load_done", 192'(load_done), 192'(m_done));
    checkOutput("rd_valid",  192'(rd_valid),  192'(e_rdv));
    checkOutput("addr_err",  192'(addr_err),  192'(e_err));
    checkOutput("dataout",   192'(dataout),   192'(e_dout));
    checkOutput("win_data",  win_data,        e_win);
  endtask

  task automatic clearBus();
    write_en = 1'b0;
    read_en  = 1'b0;
    ld_valid = 1'b0;
  endtask

  // Advance one clock with the current inputs, updating the model from its pre-edge state.
  task automatic applyStimulus();
    logic [11:0] old [64];
    bit in_range;
    old = m_mem;
    in_range = (addr < 12'd64);
    for (int k = 0; k < 16; k++) e_win[k*12 +: 12] = old[k];
    e_err = (write_en && (m_loading || !in_range)) || (read_en && !in_range);
    e_rdv = read_en;
    if (read_en) e_dout = in_range ? old[addr[5:0]] : 12'h000;
    if (write_en && !m_loading && in_range) m_mem[addr[5:0]] = datain[11:0];
    if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_count] = ld_data[11:0];
        m_count++;
        if (m_count == 16) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end else if (start_writing && !m_start_prev) begin
      m_loading = 1'b1;
      m_count   = 0;
      m_done    = 1'b0;
    end
    m_start_prev = start_writing;
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Asynchronous reset applied mid-cycle, checked before release.
  task automatic doReset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 64; k++) m_mem[k] = 12'h000;
    m_loading    = 1'b0;
    m_done       = 1'b0;
    m_start_prev = 1'b0;
    m_count      = 0;
    e_dout       = 12'h000;
    e_rdv        = 1'b0;
    e_err        = 1'b0;
    e_win        = '0;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stream loader words until the load completes or stop_after beats are taken.
  task automatic runLoad(input bit pattern, input bit rnd, input int stop_after);
    for (int cyc = 0; cyc < 200; cyc++) begin
      ld_valid = pattern ? (cyc % 3 != 2) : 1'($urandom_range(0, 1));
      ld_data  = pattern ? 17'(17'h10001 + m_count) : 17'($urandom);
      read_en  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      write_en = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      addr     = 12'($urandom_range(0, 70));
      datain   = 17'($urandom);
      applyStimulus();
      if (m_done || (stop_after > 0 && m_count >= stop_after)) break;
    end
    clearBus();
    if (stop_after == 0) checkOutput("load_completed", 192'(load_done), 192'(1'b1));
  endtask

  initial begin
    logic [191:0] pat;
    logic [11:0]  keep2;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start_writing = 1'b0;
    ld_data = '0;
    addr = '0;
    datain = '0;
    clearBus();
    #3;
    $display("[TB] reset");
    doReset();

    $display("[TB] pattern load");
    start_writing = 1'b1;
    runLoad(1'b1, 1'b0, 0);
    applyStimulus();
    for (int k = 0; k < 16; k++) pat[k*12 +: 12] = 12'(k + 1);
    checkOutput("win_pattern", win_data, pat);
    checkOutput("busy_after_load", 192'(load_busy), 192'(1'b0));

    $display("[TB] bus port");
    write_en = 1'b1; addr = 12'd5; datain = 17'h0ABC;
    applyStimulus();
    write_en = 1'b0; read_en = 1'b1;
    applyStimulus();
    checkOutput("rd_abc", 192'(dataout), 192'(12'hABC));
    checkOutput("rd_abc_valid", 192'(rd_valid), 192'(1'b1));
    write_en = 1'b1; datain = 17'h10123;
    applyStimulus();
    checkOutput("rd_first", 192'(dataout), 192'(12'hABC));
    write_en = 1'b0;
    applyStimulus();
    checkOutput("rd_new", 192'(dataout), 192'(12'h123));
    read_en = 1'b0;
    applyStimulus();
    checkOutput("dout_hold", 192'(dataout), 192'(12'h123));

    $display("[TB] errors during load");
    start_writing = 1'b0;
    applyStimulus();
    start_writing = 1'b1;
    applyStimulus();
    keep2 = m_mem[2];
    write_en = 1'b1; addr = 12'd2; datain = 17'h00FFF;
    applyStimulus();
    checkOutput("err_load_wr", 192'(addr_err), 192'(1'b1));
    write_en = 1'b0; read_en = 1'b1;
    applyStimulus();
    checkOutput("mem2_kept", 192'(dataout), 192'(keep2));
    addr = 12'd64;
    applyStimulus();
    checkOutput("err_oob_rd", 192'(addr_err), 192'(1'b1));
    checkOutput("oob_rd_valid", 192'(rd_valid), 192'(1'b1));
    checkOutput("oob_rd_data", 192'(dataout), 192'(12'h000));
    runLoad(1'b0, 1'b1, 0);

    $display("[TB] reset mid-load");
    start_writing = 1'b0;
    applyStimulus();
    start_writing = 1'b1;
    runLoad(1'b0, 1'b0, 7);
    start_writing = 1'b0;
    doReset();
    checkOutput("win_cleared", win_data, 192'(0));
    applyStimulus();
    start_writing = 1'b1;
    runLoad(1'b0, 1'b0, 0);

    $display("[TB] held start");
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = 17'($urandom);
      applyStimulus();
    end
    checkOutput("no_retrigger", 192'(load_busy), 192'(1'b0));
    clearBus();
    start_writing = 1'b0;
    applyStimulus();
    start_writing = 1'b1;
    applyStimulus();
    checkOutput("restart_done_clr", 192'(load_done), 192'(1'b0));
    checkOutput("restart_busy", 192'(load_busy), 192'(1'b1));
    runLoad(1'b0, 1'b1, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) start_writing = ~start_writing;
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = 17'($urandom);
      write_en = 1'($urandom_range(0, 1));
      read_en  = 1'($urandom_range(0, 1));
      addr     = 12'($urandom_range(0, 80));
      datain   = 17'($urandom);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
